// File: rtl/button_event_if.sv
// Event stream from the button front-end to the command logic.
// The master drives a show-ahead head entry and the slave acknowledges it with ev_ready.
interface button_event_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_btn;
    logic       ev_rise;

    modport master (output ev_valid, output ev_btn, output ev_rise, input ev_ready);
    modport slave  (input ev_valid, input ev_btn, input ev_rise, output ev_ready);
endinterface

// File: rtl/button_event_scheduler.sv
// Button front-end: synchronise, debounce and edge-qualify N raw buttons.
// Qualified events are arbitrated round-robin into a small show-ahead event FIFO.
module button_event_scheduler #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BTN-1:0]     btn_raw_i,
    input  logic [2*N_BTN-1:0]   edge_cfg_i,
    button_event_if.master       ev_if,
    output logic [N_BTN-1:0]     btn_level_o,
    output logic [N_BTN-1:0]     overflow_o,
    input  logic                 clr_ovf_i
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int IDX_W  = $clog2(N_BTN);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_BTN - 1);
    localparam logic [FCNT_W-1:0] FIFO_CAP = FCNT_W'(FIFO_DEPTH);

    logic [N_BTN-1:0] sync0_q, sync1_q;
    logic [N_BTN-1:0] level_q, level_d, level_prev_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] pulse_q, pulse_d, pol_q, pol_d;
    logic [N_BTN-1:0] pend_q, pend_d, pend_pol_q, pend_pol_d;
    logic [N_BTN-1:0] ovf_q, ovf_d, ovf_set_s;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [3:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;

    logic             ev_valid_s, pop_s, can_accept_s;
    logic             gnt_valid_s;
    logic [IDX_W-1:0] gnt_idx_s, cand_s;
    logic [N_BTN-1:0] gnt_vec_s;
    logic [3:0]       entry_s;
    int               cand_int_s;

    // Debounce: count consecutive disagreeing samples, toggle the level on the last one.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge qualification; mode is sampled while the transition is visible.
    always_comb begin
        pulse_d = '0;
        pol_d   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            pol_d[i] = level_q[i];
            case (edge_cfg_i[2*i +: 2])
                2'b00:   pulse_d[i] = level_q[i] & ~level_prev_q[i];
                2'b01:   pulse_d[i] = ~level_q[i] & level_prev_q[i];
                default: pulse_d[i] = level_q[i] ^ level_prev_q[i];
            endcase
        end
    end

    assign ev_valid_s   = (count_q != '0);
    assign pop_s        = ev_valid_s & ev_if.ev_ready;
    assign can_accept_s = (count_q < FIFO_CAP) | pop_s;

    // Round-robin search starting at ptr_q; first pending button wins.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        cand_int_s  = 0;
        cand_s      = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand_int_s  = int'(ptr_q) + k;
            cand_int_s  = (cand_int_s >= N_BTN) ? (cand_int_s - N_BTN) : cand_int_s;
            cand_s      = IDX_W'(cand_int_s);
            gnt_idx_s   = (!gnt_valid_s && pend_q[cand_s]) ? cand_s : gnt_idx_s;
            gnt_valid_s = gnt_valid_s | pend_q[cand_s];
        end
        gnt_valid_s = gnt_valid_s & can_accept_s;
        gnt_vec_s   = gnt_valid_s ? (N_BTN'(1) << gnt_idx_s) : '0;
        ptr_d       = ptr_q;
        if (gnt_valid_s) begin
            ptr_d = (gnt_idx_s == IDX_LAST) ? '0 : (gnt_idx_s + IDX_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pending slots: a pulse on a granted button reloads, on a busy one it is lost.
    always_comb begin
        pend_d     = pend_q;
        pend_pol_d = pend_pol_q;
        ovf_set_s  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case ({pulse_q[i], gnt_vec_s[i]})
                2'b11: begin
                    pend_d[i]     = 1'b1;
                    pend_pol_d[i] = pol_q[i];
                end
                2'b10: begin
                    if (pend_q[i]) begin
                        ovf_set_s[i] = 1'b1;
                    end else begin
                        pend_d[i]     = 1'b1;
                        pend_pol_d[i] = pol_q[i];
                    end
                end
                2'b01:   pend_d[i] = 1'b0;
                default: pend_d[i] = pend_q[i];
            endcase
        end
        ovf_d = (ovf_q & ~{N_BTN{clr_ovf_i}}) | ovf_set_s;
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        entry_s  = {3'(gnt_idx_s), pend_pol_q[gnt_idx_s]};
        wr_ptr_d = gnt_valid_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({gnt_valid_s, pop_s})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers for every pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            pulse_q      <= '0;
            pol_q        <= '0;
            pend_q       <= '0;
            pend_pol_q   <= '0;
            ovf_q        <= '0;
            ptr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_mem_q[j] <= 4'b0000;
            end
        end else begin
            sync0_q      <= btn_raw_i;
            sync1_q      <= sync0_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= pulse_d;
            pol_q        <= pol_d;
            pend_q       <= pend_d;
            pend_pol_q   <= pend_pol_d;
            ovf_q        <= ovf_d;
            ptr_q        <= ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (gnt_valid_s) begin
                fifo_mem_q[wr_ptr_q] <= entry_s;
            end else begin
                fifo_mem_q[wr_ptr_q] <= fifo_mem_q[wr_ptr_q];
            end
        end
    end

    assign ev_if.ev_valid = ev_valid_s;
    assign ev_if.ev_btn   = fifo_mem_q[rd_ptr_q][3:1];
    assign ev_if.ev_rise  = fifo_mem_q[rd_ptr_q][0];
    assign btn_level_o    = level_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler: expected events are queued as
// stimulus is applied and compared in order as the DUT hands them out.
module tb_button_event_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   btn_raw;
    logic [2*N-1:0] edge_cfg;
    logic [N-1:0]   btn_level, overflow;
    logic           clr_ovf;

    button_event_if ev_if();

    button_event_scheduler #(.N_BTN(N), .DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw_i   (btn_raw),
        .edge_cfg_i  (edge_cfg),
        .ev_if       (ev_if),
        .btn_level_o (btn_level),
        .overflow_o  (overflow),
        .clr_ovf_i   (clr_ovf)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         drained      = 0;
    logic [3:0] sb_q [$];
    logic [3:0] exp_ev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_ev(input int btn, input logic rise);
        sb_q.push_back({3'(btn), rise});
    endtask

    // Every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ev_if.ev_valid && ev_if.ev_ready) begin
            drained++;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_ev = sb_q.pop_front();
                check("ev_btn", 32'(ev_if.ev_btn), 32'(exp_ev[3:1]));
                check("ev_rise", 32'(ev_if.ev_rise), 32'(exp_ev[0]));
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        btn_raw        = '0;
        edge_cfg       = '0;
        clr_ovf        = 1'b0;
        ev_if.ev_ready = 1'b1;
        tick_n(3);
        check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_btn", 32'(ev_if.ev_btn), 32'd0);
        rst_n = 1'b1;
        tick_n(3);

        // Latency: raw change before edge 1, level at 18, one-cycle event at 21.
        expect_ev(2, 1'b1);
        btn_raw[2] = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_valid_c%0d", t), 32'(ev_if.ev_valid), 32'(t == 21));
            check($sformatf("lat_level_c%0d", t), 32'(btn_level[2]), 32'(t >= 18));
        end
        tick_n(1);
        btn_raw[2] = 1'b0;
        tick_n(40);

        // Short glitch is filtered.
        btn_raw[0] = 1'b1;
        tick_n(10);
        btn_raw[0] = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick_n(1);
            check("glitch_level", 32'(btn_level[0]), 32'd0);
        end
        check("glitch_drained", 32'(drained), 32'd1);

        // Both-edge then falling-only mode on button 0.
        edge_cfg[1:0] = 2'b10;
        expect_ev(0, 1'b1);
        expect_ev(0, 1'b0);
        btn_raw[0] = 1'b1;
        tick_n(40);
        check("both_level", 32'(btn_level[0]), 32'd1);
        btn_raw[0] = 1'b0;
        tick_n(40);
        check("both_drained", 32'(drained), 32'd3);
        edge_cfg[1:0] = 2'b01;
        expect_ev(0, 1'b0);
        btn_raw[0] = 1'b1;
        tick_n(40);
        btn_raw[0] = 1'b0;
        tick_n(40);
        check("fall_drained", 32'(drained), 32'd4);
        edge_cfg = '0;

        // Round-robin: a lone press of 3 wraps the pointer to 0, a lone press of 1 moves it to 2.
        expect_ev(3, 1'b1);
        btn_raw = 4'b1000;
        tick_n(40);
        btn_raw = 4'b0000;
        tick_n(40);
        expect_ev(0, 1'b1);
        expect_ev(1, 1'b1);
        expect_ev(3, 1'b1);
        btn_raw = 4'b1011;
        tick_n(40);
        btn_raw = 4'b0000;
        tick_n(40);
        expect_ev(1, 1'b1);
        btn_raw = 4'b0010;
        tick_n(40);
        btn_raw = 4'b0000;
        tick_n(40);
        expect_ev(3, 1'b1);
        expect_ev(0, 1'b1);
        expect_ev(1, 1'b1);
        btn_raw = 4'b1011;
        tick_n(40);
        btn_raw = 4'b0000;
        tick_n(40);
        check("rr_drained", 32'(drained), 32'd12);

        // Backpressure: four in the FIFO, one pending, the sixth lost.
        ev_if.ev_ready = 1'b0;
        for (int r = 0; r < 6; r++) begin
            if (r < 5) expect_ev(1, 1'b1);
            btn_raw[1] = 1'b1;
            tick_n(30);
            btn_raw[1] = 1'b0;
            tick_n(30);
        end
        check("bp_ovf", 32'(overflow), 32'h2);
        check("bp_valid", 32'(ev_if.ev_valid), 32'd1);
        check("bp_head_btn", 32'(ev_if.ev_btn), 32'd1);
        check("bp_drained_none", 32'(drained), 32'd12);
        ev_if.ev_ready = 1'b1;
        tick_n(20);
        check("bp_drained", 32'(drained), 32'd17);
        check("bp_valid_empty", 32'(ev_if.ev_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'h2);
        clr_ovf = 1'b1;
        tick_n(1);
        clr_ovf = 1'b0;
        check("bp_ovf_clr", 32'(overflow), 32'd0);

        // Async reset discards queued events.
        ev_if.ev_ready = 1'b0;
        btn_raw = 4'b0111;
        tick_n(30);
        check("rq_valid", 32'(ev_if.ev_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rq_async_valid", 32'(ev_if.ev_valid), 32'd0);
        check("rq_async_level", 32'(btn_level), 32'd0);
        btn_raw = 4'b0000;
        tick_n(3);
        rst_n = 1'b1;
        ev_if.ev_ready = 1'b1;
        tick_n(40);
        check("rq_no_residual", 32'(drained), 32'd17);
        check("rq_idle_valid", 32'(ev_if.ev_valid), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
